// File: rtl/arb_pkg.sv
// Shared constants for the fair-arbiter requester agents.
package arb_pkg;

  // Cycles between a request and the arbiter's registered grant answering it.
  localparam int ARB_GRANT_LAT = 1;

  // Default geometry of a requester agent.
  localparam int ARB_DATA_W   = 8;
  localparam int ARB_DEPTH    = 4;
  localparam int ARB_MAX_WAIT = 15;

endpackage

// File: rtl/arb_requester_fifo.sv
// Synchronous FIFO buffering producer words ahead of arbitration.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import arb_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W,
  parameter int DEPTH  = ARB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && (count_q != '0);

  // Next-state pointers and occupancy; simultaneous push and pop keep count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for one port of the two-input fair arbiter.
// Buffers producer words, requests one transfer per cycle, releases one
// word per qualified grant and flags starvation of a pending request.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W   = ARB_DATA_W,
  parameter int DEPTH    = ARB_DEPTH,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     req,
  input  logic                     grant,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     starve
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    if (v == WAIT_MAX) return v;
    return v + WW'(1);
  endfunction

  logic                     push;
  logic                     gq;
  logic                     req_last;
  logic [DATA_W-1:0]        head;
  logic [ARB_GRANT_LAT-1:0] req_hist_q, req_hist_d;
  logic [WW-1:0]            wait_q, wait_d;
  logic                     starve_q, starve_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;

  // No bypass: a full FIFO refuses input even while a word is being popped.
  assign in_ready = (count < FULL_CNT);
  assign push     = in_valid && in_ready;

  // A grant only counts if it answers a request made ARB_GRANT_LAT cycles ago;
  // the arbiter parks its grant on an idle port, which must be ignored.
  assign req_last = req_hist_q[ARB_GRANT_LAT-1];
  assign gq       = grant && req_last;

  // The word leaving this cycle is not requested again; a push this cycle
  // only shows up in count (and thus req) next cycle.
  assign req = reset_n && (count > CW'(gq));

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (in_data),
    .pop_i       (gq),
    .head_o      (head),
    .count_o     (count)
  );

  // Next state for request history, wait counter, starvation flag and output.
  always_comb begin
    req_hist_d  = ARB_GRANT_LAT'({req_hist_q, req});
    wait_d      = (!req || gq) ? '0 : sat_inc(wait_q);
    // Starvation is judged on the same cycle's clear conditions so the flag
    // falls right after a qualified grant or a dropped request.
    starve_d    = req && !gq && (wait_q == WAIT_MAX);
    out_valid_d = gq;
    out_data_d  = gq ? head : out_data_q;
  end

  // Registered state; reset drops request history and clears the outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_hist_q  <= '0;
      wait_q      <= '0;
      starve_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      req_hist_q  <= req_hist_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign starve    = starve_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: two instances sharing a small fair
// arbiter model; instance A can also be driven by hand-written grants.
module tb_arb_requester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       in_valid_a, in_ready_a, req_a, grant_a, grant_a_w, out_valid_a, starve_a;
  logic [7:0] in_data_a, out_data_a;
  logic [2:0] count_a;
  logic       in_valid_b, in_ready_b, req_b, grant_b_w, out_valid_b, starve_b;
  logic [7:0] in_data_b, out_data_b;
  logic [2:0] count_b;

  logic arb_en, g1_q, g2_q, last_b_q;
  int   errors = 0;
  int   checks = 0;

  assign grant_a_w = arb_en ? g1_q : grant_a;
  assign grant_b_w = arb_en ? g2_q : 1'b0;

  arb_requester #(.DATA_W(8), .DEPTH(4), .MAX_WAIT(15)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .req(req_a), .grant(grant_a_w), .out_valid(out_valid_a),
    .out_data(out_data_a), .count(count_a), .starve(starve_a));

  arb_requester #(.DATA_W(8), .DEPTH(4), .MAX_WAIT(15)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .req(req_b), .grant(grant_b_w), .out_valid(out_valid_b),
    .out_data(out_data_b), .count(count_b), .starve(starve_b));

  // Fair two-input arbiter with registered grant, alternating under contention.
  always @(posedge clk) begin
    if (!reset_n || !arb_en) begin
      g1_q <= 1'b0;
      g2_q <= 1'b0;
      if (!reset_n) last_b_q <= 1'b1;
    end else if (req_a && req_b) begin
      g1_q     <= last_b_q;
      g2_q     <= !last_b_q;
      last_b_q <= !last_b_q;
    end else begin
      g1_q <= req_a;
      g2_q <= req_b;
      if (req_a) last_b_q <= 1'b0;
      else if (req_b) last_b_q <= 1'b1;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step();
    step();
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_a); end
    checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a); end
    checks++; if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data_a); end
    checks++; if (starve_a !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b expected 0", starve_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_a); end
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    in_valid_a = 1'b1; in_data_a = 8'hA5; grant_a = 1'b0;
    @(negedge clk);
    checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL single_req_c0: got %b expected 0", req_a); end
    step();
    in_valid_a = 1'b0;
    @(negedge clk);
    checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL single_count_c1: got %0d expected 1", count_a); end
    checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL single_req_c1: got %b expected 1", req_a); end
    step();
    grant_a = 1'b1;
    @(negedge clk);
    checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL single_req_c2: got %b expected 0", req_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL single_ov_c2: got %b expected 0", out_valid_a); end
    step();
    grant_a = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL single_ov_c3: got %b expected 1", out_valid_a); end
    checks++; if (out_data_a !== 8'hA5) begin errors++; $display("FAIL single_data_c3: got %h expected a5", out_data_a); end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL single_count_c3: got %0d expected 0", count_a); end
    step();
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL single_ov_c4: got %b expected 0", out_valid_a); end
    checks++; if (out_data_a !== 8'hA5) begin errors++; $display("FAIL single_hold_c4: got %h expected a5", out_data_a); end
    step();
  endtask

  task automatic test_burst;
    int er[8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    int ec[8] = '{0, 1, 2, 2, 2, 1, 0, 0};
    int eo[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    for (int k = 0; k < 8; k++) begin
      in_valid_a = (k < 4);
      in_data_a  = 8'(k + 1);
      grant_a    = 1'b1;
      @(negedge clk);
      checks++; if (req_a !== 1'(er[k])) begin errors++; $display("FAIL burst_req_c%0d: got %b expected %0d", k, req_a, er[k]); end
      checks++; if (count_a !== 3'(ec[k])) begin errors++; $display("FAIL burst_count_c%0d: got %0d expected %0d", k, count_a, ec[k]); end
      checks++; if (out_valid_a !== 1'(eo[k])) begin errors++; $display("FAIL burst_ov_c%0d: got %b expected %0d", k, out_valid_a, eo[k]); end
      if (eo[k] == 1) begin
        checks++; if (out_data_a !== 8'(k - 2)) begin errors++; $display("FAIL burst_data_c%0d: got %h expected %h", k, out_data_a, 8'(k - 2)); end
      end
      step();
    end
    in_valid_a = 1'b0;
    grant_a    = 1'b0;
  endtask

  task automatic test_stray_grant;
    for (int k = 0; k < 4; k++) begin
      grant_a = (k < 3);
      @(negedge clk);
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stray_ov_c%0d: got %b expected 0", k, out_valid_a); end
      checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL stray_count_c%0d: got %0d expected 0", k, count_a); end
      checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL stray_req_c%0d: got %b expected 0", k, req_a); end
      step();
    end
    grant_a = 1'b0;
  endtask

  task automatic test_full;
    logic [7:0] q[$];
    logic [7:0] got;
    grant_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_a = 1'b1; in_data_a = 8'(8'h10 + k);
      @(negedge clk);
      checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL full_ready_c%0d: got %b expected 1", k, in_ready_a); end
      step();
    end
    in_data_a = 8'h14;
    @(negedge clk);
    checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count_a); end
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", in_ready_a); end
    step();
    in_data_a = 8'h15; grant_a = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b expected 0", in_ready_a); end
    checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL full_pop_req: got %b expected 1", req_a); end
    step();
    in_valid_a = 1'b0; grant_a = 1'b0;
    @(negedge clk);
    checks++; if (count_a !== 3'd3) begin errors++; $display("FAIL full_after_count: got %0d expected 3", count_a); end
    checks++; if (out_valid_a !== 1'b1 || out_data_a !== 8'h10) begin errors++; $display("FAIL full_first_out: got %b/%h expected 1/10", out_valid_a, out_data_a); end
    step();
    grant_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid_a === 1'b1) q.push_back(out_data_a);
      step();
    end
    grant_a = 1'b0;
    checks++; if (q.size() != 3) begin errors++; $display("FAIL full_drain_len: got %0d expected 3", q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      checks++; if (got !== 8'(8'h11 + i)) begin errors++; $display("FAIL full_drain_%0d: got %h expected %h", i, got, 8'(8'h11 + i)); end
    end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL full_drain_count: got %0d expected 0", count_a); end
  endtask

  task automatic test_starve;
    in_valid_a = 1'b1; in_data_a = 8'h5C; grant_a = 1'b0;
    step();
    in_valid_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      grant_a = (k == 20);
      @(negedge clk);
      checks++; if (starve_a !== (k >= 17)) begin errors++; $display("FAIL starve_c%0d: got %b expected %b", k, starve_a, (k >= 17)); end
      step();
    end
    grant_a = 1'b0;
    @(negedge clk);
    checks++; if (starve_a !== 1'b0) begin errors++; $display("FAIL starve_fall_c21: got %b expected 0", starve_a); end
    checks++; if (out_valid_a !== 1'b1 || out_data_a !== 8'h5C) begin errors++; $display("FAIL starve_out_c21: got %b/%h expected 1/5c", out_valid_a, out_data_a); end
    step();
  endtask

  task automatic test_two_instances;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         ord[$];
    logic [7:0] got;
    int         o;
    grant_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_a = 1'b1; in_data_a = 8'(8'h20 + k);
      in_valid_b = 1'b1; in_data_b = 8'(8'h30 + k);
      step();
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    arb_en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (out_valid_a === 1'b1) begin qa.push_back(out_data_a); ord.push_back(0); end
      if (out_valid_b === 1'b1) begin qb.push_back(out_data_b); ord.push_back(1); end
      step();
    end
    arb_en = 1'b0;
    checks++; if (ord.size() != 8) begin errors++; $display("FAIL two_total: got %0d expected 8", ord.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      checks++; if (got !== 8'(8'h20 + i)) begin errors++; $display("FAIL two_a_%0d: got %h expected %h", i, got, 8'(8'h20 + i)); end
      got = (i < qb.size()) ? qb[i] : 8'hxx;
      checks++; if (got !== 8'(8'h30 + i)) begin errors++; $display("FAIL two_b_%0d: got %h expected %h", i, got, 8'(8'h30 + i)); end
    end
    for (int i = 0; i < 8; i++) begin
      o = (i < ord.size()) ? ord[i] : -1;
      checks++; if (o != (i % 2)) begin errors++; $display("FAIL two_order_%0d: got %0d expected %0d", i, o, i % 2); end
    end
  endtask

  task automatic test_reset_mid;
    grant_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_a = 1'b1; in_data_a = 8'(8'h40 + k);
      step();
    end
    in_valid_a = 1'b0;
    @(negedge clk);
    checks++; if (count_a !== 3'd3 || req_a !== 1'b1) begin errors++; $display("FAIL rmid_pre: got count %0d req %b expected 3/1", count_a, req_a); end
    step();
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL rmid_req_in_reset: got %b expected 0", req_a); end
    step();
    reset_n = 1'b1; grant_a = 1'b1;
    @(negedge clk);
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count_a); end
    checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b expected 0", req_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rmid_ov: got %b expected 0", out_valid_a); end
    step();
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rmid_grant_ov: got %b expected 0", out_valid_a); end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL rmid_grant_count: got %0d expected 0", count_a); end
    step();
    grant_a = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid_a = 1'b0; in_data_a = 8'h00; grant_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = 8'h00;
    arb_en     = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_stray_grant();
    test_full();
    test_starve();
    test_two_instances();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
# arb_requester

Requester-side agent for the two-input fair arbiter: buffers outgoing words from a local producer, raises `req` toward one arbiter input, and releases exactly one word per qualified `grant`. One instance sits on each arbiter port (`req_1`/`grant_1`, `req_2`/`grant_2`). It also reports starvation when a request goes unserved too long.

## Interface
- `DATA_W`, 8, width of a buffered word
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `MAX_WAIT`, 15, cycles of unserved request before `starve` asserts (≥1)

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, synchronous and active-low
- `in_valid`  in  1  producer offers `in_data`
- `in_ready`  out  1  FIFO can accept
- `in_data`  in  DATA_W  producer word
- `req`  out  1  request to arbiter
- `grant`  in  1  registered grant from arbiter
- `out_valid`  out  1  one-cycle pulse, granted word on `out_data`
- `out_data`  out  DATA_W  granted word, held until next pulse
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `starve`  out  1  wait counter saturated

## Operation
- Push when `in_valid && in_ready`; `in_ready = (count < DEPTH)`; no same-cycle bypass when full.
- Arbiter contract: `grant` in cycle t+1 answers `req` in cycle t. Each cycle's `req` requests exactly one transfer.
- `req_last` register holds previous-cycle `req`. Qualified grant `gq = grant && req_last`. A `grant` with `req_last=0` is ignored; the arbiter can drive its default grant with no request pending.
- On `gq`: pop head at end of cycle; `out_data` <= head, `out_valid` <= 1 for next cycle.
- `req = reset_n && (count > gq)`. This is combinational from `grant`, so the word being popped is never requested twice.
- Push and pop in the same cycle leave `count` unchanged. Pointers wrap modulo DEPTH.
- Wait counter, width $clog2(MAX_WAIT+1):
  - cleared when `!req` or `gq`
  - otherwise incremented, saturating at MAX_WAIT
  - `starve = (wait_cnt == MAX_WAIT)`, registered.

## Timing
- Reset (`reset_n` low at an edge) clears `count`, pointers, `req_last`, `wait_cnt`, `out_valid`, `starve` to 0 and `out_data` to 0. `req` is forced 0 combinationally while `reset_n` is low. Reset mid-transfer drops all buffered words; a `grant` in the first cycle after reset is unqualified.
- Latency: push accepted cycle 0 → `req` cycle 1 → `grant` cycle 2 → `out_valid` cycle 3.
- Back-to-back: with `count ≥ 2` and `grant` every cycle, `req` stays high and `out_valid` pulses every cycle.
- `count == 1` while granted: `req` drops in the grant cycle unless a push lands that cycle. The push raises `req` only in the following cycle.
- Full FIFO with a pop in the same cycle: `in_ready` stays 0 that cycle.
- `starve` rises MAX_WAIT+1 cycles after `req` rises with no `gq`. It falls the cycle after a `gq` or after `req` drops.

## Structure
- Shared package `arb_pkg`: `ARB_GRANT_LAT = 1` (grant latency constant) and default DATA_W/DEPTH localparams.
- Sub-module `sync_fifo` (DATA_W, DEPTH; push/pop, head, count, same reset). `arb_requester` adds the request/qualify logic, wait counter and output register.

## Test plan
- Single word: push 0xA5 at cycle 0, arbiter grants in cycle 2 → `req` high only in cycle 1; `out_valid` with 0xA5 in cycle 3; `count` 1→0.
- Burst: push 0x01..0x04, continuous grant → `out_data` 0x01..0x04 on four consecutive `out_valid` cycles; `req` low after the last; no extra pop.
- Stray grant: FIFO empty, `grant`=1 for 3 cycles → no `out_valid`, `count` stays 0.
- Two instances on the arbiter, both 4 words deep → alternating `out_valid` between instances, all 8 words delivered in order per instance.
- Starvation with MAX_WAIT=15: one word, grant held 0 → `starve`=1 at cycle 17 after `req` rises. Grant at cycle 20 → `starve`=0 at cycle 21.
- Reset mid-operation: 3 words buffered, `reset_n`=0 for one edge → `count`=0, `req`=0, `out_valid`=0. A following grant produces no output.
